// File: rtl/encap_ct_streamer_pkg.sv
// Shared definitions for the ciphertext streamer: section encodings,
// controller states and the per-parameter-set code length table.
`ifndef ENCAP_CT_STREAMER_CLOG2
`define ENCAP_CT_STREAMER_CLOG2
`define CLOG2(x) $clog2(x)
`endif

package encap_ct_streamer_pkg;

  // Section encodings shared by encap_out_type and dout_sect.
  typedef enum logic [1:0] {
    SEC_NONE = 2'd0,
    SEC_D    = 2'd1,
    SEC_U    = 2'd2,
    SEC_V    = 2'd3
  } sect_e;

  // Controller states, exported on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Code length N in bits for each parameter set.
  localparam int N_HQC128 = 17669;
  localparam int N_HQC192 = 35851;
  localparam int N_HQC256 = 57637;

  // Number of 32-bit words making up the d section.
  localparam int D_WORDS = 16;

endpackage

// File: rtl/encap_ct_streamer_if.sv
// Bundles the encap read port and the outgoing ciphertext byte stream.
// Stream handshake: a word moves when dout_valid && dout_ready at a rising
// clk edge; once dout_valid is raised, dout/keep/sect/last/valid stay
// unchanged until that transfer happens.
interface encap_ct_streamer_if #(
  parameter int RAMWIDTH     = 256,
  parameter int LOG_RAMDEPTH = 7
);
  logic [1:0]              encap_out_type;
  logic                    encap_out_en;
  logic [LOG_RAMDEPTH-1:0] encap_out_addr;
  logic [RAMWIDTH-1:0]     encap_out;
  logic [31:0]             dout;
  logic [3:0]              dout_keep;
  logic [1:0]              dout_sect;
  logic                    dout_last;
  logic                    dout_valid;
  logic                    dout_ready;

  modport master (
    output encap_out_type, encap_out_en, encap_out_addr,
    input  encap_out,
    output dout, dout_keep, dout_sect, dout_last, dout_valid,
    input  dout_ready
  );

  modport slave (
    input  encap_out_type, encap_out_en, encap_out_addr,
    output encap_out,
    input  dout, dout_keep, dout_sect, dout_last, dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/encap_ct_streamer.sv
// Reads u, v and d out of the encap core memories and re-emits them as a
// 32-bit byte stream with byte keep and per-section last flags.
module encap_ct_streamer
  import encap_ct_streamer_pkg::*;
#(
  parameter string parameter_set = "hqc128",
  parameter int    RAMWIDTH      = 256
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  output logic   busy,
  output logic   done,
  output state_e dbg_state,
  encap_ct_streamer_if.master bus
);

  localparam int N = (parameter_set == "hqc256") ? N_HQC256 :
                     (parameter_set == "hqc192") ? N_HQC192 : N_HQC128;
  localparam int N_B          = N + (8 - N % 8) % 8;
  localparam int RAMDEPTH     = (N + (RAMWIDTH - N % RAMWIDTH) % RAMWIDTH) / RAMWIDTH;
  localparam int LOG_RAMDEPTH = `CLOG2(RAMDEPTH);
  localparam int LAST_BYTES   = (N_B - (RAMDEPTH - 1) * RAMWIDTH) / 8;
  localparam int NCHUNK_FULL  = RAMWIDTH / 32;
  localparam int NCHUNK_LAST  = (LAST_BYTES + 3) / 4;
  localparam int LAST_REM     = LAST_BYTES % 4;
  localparam int CW           = (NCHUNK_FULL > 1) ? $clog2(NCHUNK_FULL) : 1;
  localparam logic [3:0] LAST_KEEP = (LAST_REM == 0) ? 4'hF : 4'((1 << LAST_REM) - 1);

  state_e                  state_q, state_d;
  sect_e                   sect_q, sect_d;
  logic [LOG_RAMDEPTH-1:0] addr_q, addr_d;
  logic [CW-1:0]           chunk_q, chunk_d;
  logic [RAMWIDTH-1:0]     buf_q, buf_d;

  logic                    last_addr;
  logic                    last_chunk;
  logic [CW-1:0]           last_idx;
  logic [3:0]              keep;
  logic [31:0]             raw;
  logic [31:0]             data;
  logic                    fire;

  assign dbg_state = state_q;

  // State, position and word buffer; rst drops everything back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sect_q  <= SEC_NONE;
      addr_q  <= '0;
      chunk_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      sect_q  <= sect_d;
      addr_q  <= addr_d;
      chunk_q <= chunk_d;
      buf_q   <= buf_d;
    end
  end

  // Chunk selection, tail-word keep and zeroing of padding bytes.
  always_comb begin
    if (sect_q == SEC_D) last_addr = (addr_q == LOG_RAMDEPTH'(D_WORDS - 1));
    else                 last_addr = (addr_q == LOG_RAMDEPTH'(RAMDEPTH - 1));
    if (sect_q == SEC_D) last_idx = '0;
    else if (last_addr)  last_idx = CW'(NCHUNK_LAST - 1);
    else                 last_idx = CW'(NCHUNK_FULL - 1);
    last_chunk = (chunk_q == last_idx);
    keep = (sect_q != SEC_D && last_addr && last_chunk) ? LAST_KEEP : 4'hF;
    raw = '0;
    for (int i = 0; i < NCHUNK_FULL; i++) begin
      if (chunk_q == CW'(i)) raw = buf_q[32*i +: 32];
    end
    data = '0;
    for (int b = 0; b < 4; b++) begin
      data[8*b +: 8] = keep[b] ? raw[8*b +: 8] : 8'h00;
    end
  end

  // Controller: next state, position updates and all port outputs.
  always_comb begin
    state_d = state_q;
    sect_d  = sect_q;
    addr_d  = addr_q;
    chunk_d = chunk_q;
    buf_d   = buf_q;
    fire    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    bus.encap_out_en   = 1'b0;
    bus.encap_out_type = 2'b00;
    bus.encap_out_addr = '0;
    bus.dout       = '0;
    bus.dout_keep  = 4'h0;
    bus.dout_sect  = 2'b00;
    bus.dout_last  = 1'b0;
    bus.dout_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sect_d  = SEC_U;
          addr_d  = '0;
          chunk_d = '0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        busy = 1'b1;
        bus.encap_out_en   = 1'b1;
        bus.encap_out_type = sect_q;
        bus.encap_out_addr = addr_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busy    = 1'b1;
        buf_d   = bus.encap_out;
        chunk_d = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        bus.dout       = data;
        bus.dout_keep  = keep;
        bus.dout_sect  = sect_q;
        bus.dout_last  = last_addr && last_chunk;
        bus.dout_valid = 1'b1;
        fire = bus.dout_ready;
        if (fire) begin
          if (!last_chunk) begin
            chunk_d = chunk_q + 1'b1;
          end else if (!last_addr) begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_RD;
          end else if (sect_q == SEC_U) begin
            sect_d  = SEC_V;
            addr_d  = '0;
            state_d = ST_RD;
          end else if (sect_q == SEC_V) begin
            sect_d  = SEC_D;
            addr_d  = '0;
            state_d = ST_RD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_encap_ct_streamer.sv
// Bench for the ciphertext streamer: an hqc128 instance exercised with full
// throughput, random backpressure, a stray start and a mid-stream reset, and
// an hqc256 instance checking the two-chunk tail word.
module tb_encap_ct_streamer;
  import encap_ct_streamer_pkg::*;

  localparam int RW      = 256;
  localparam int LOG_A   = 7;
  localparam int LOG_B   = 8;
  localparam int BYTES_A = 17672 / 8;
  localparam int BYTES_B = 57640 / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic busy_a, busy_b, done_a, done_b;
  state_e dbg_a, dbg_b;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  encap_ct_streamer_if #(.RAMWIDTH(RW), .LOG_RAMDEPTH(LOG_A)) bus_a ();
  encap_ct_streamer_if #(.RAMWIDTH(RW), .LOG_RAMDEPTH(LOG_B)) bus_b ();

  encap_ct_streamer #(.parameter_set("hqc128"), .RAMWIDTH(RW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .dbg_state(dbg_a), .bus(bus_a)
  );

  encap_ct_streamer #(.parameter_set("hqc256"), .RAMWIDTH(RW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .dbg_state(dbg_b), .bus(bus_b)
  );

  // ---------------- encap memory model ----------------
  function automatic logic [7:0] mem_byte(input int sect, input int addr, input int j);
    int off;
    off = (sect == 2) ? 0 : (sect == 3) ? 'h55 : 'hAA;
    return 8'((j + addr * 29 + off) % 256);
  endfunction

  function automatic logic [RW-1:0] mem_word(input int sect, input int addr);
    logic [RW-1:0] w;
    for (int j = 0; j < RW / 8; j++) w[8*j +: 8] = mem_byte(sect, addr, j);
    return w;
  endfunction

  // Read data appears one cycle after en; garbage otherwise.
  always @(posedge clk) begin
    if (bus_a.encap_out_en) bus_a.encap_out <= mem_word(int'(bus_a.encap_out_type), int'(bus_a.encap_out_addr));
    else bus_a.encap_out <= {8{$urandom}};
    if (bus_b.encap_out_en) bus_b.encap_out <= mem_word(int'(bus_b.encap_out_type), int'(bus_b.encap_out_addr));
    else bus_b.encap_out <= {8{$urandom}};
  end

  // ---------------- scoreboard state ----------------
  logic [38:0] exp_a[$];
  logic [38:0] exp_b[$];
  logic [38:0] model_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt_a, done_cnt_b, words_a, cnt_a_u, cnt_a_v, cnt_a_d, cnt_b_u;
  logic [31:0] first_u_a[2];
  logic [35:0] ulast_a, ulast_b;
  bit hold_a = 1'b0;
  logic [38:0] held_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference stream: each u/v section is its byte string (nbytes long,
  // 32 bytes per memory word) cut into 4-byte words, zero padded; d is the
  // low 32 bits of 16 memory words. Entry = {sect, last, keep, data}.
  task automatic build_model(input int nbytes);
    int nw, k, sect;
    logic [31:0] data;
    logic [3:0] keep;
    logic [RW-1:0] w;
    model_q.delete();
    for (int s = 0; s < 2; s++) begin
      sect = (s == 0) ? 2 : 3;
      nw = (nbytes + 3) / 4;
      for (int i = 0; i < nw; i++) begin
        data = '0;
        keep = '0;
        for (int b = 0; b < 4; b++) begin
          k = 4 * i + b;
          if (k < nbytes) begin
            data[8*b +: 8] = mem_byte(sect, k / 32, k % 32);
            keep[b] = 1'b1;
          end
        end
        model_q.push_back({2'(sect), (i == nw - 1), keep, data});
      end
    end
    for (int a = 0; a < D_WORDS; a++) begin
      w = mem_word(1, a);
      model_q.push_back({2'd1, (a == D_WORDS - 1), 4'hF, w[31:0]});
    end
  endtask

  task automatic clear_counts();
    done_cnt_a = 0; done_cnt_b = 0; words_a = 0;
    cnt_a_u = 0; cnt_a_v = 0; cnt_a_d = 0; cnt_b_u = 0;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [38:0] cur, e;
    cur = {bus_a.dout_sect, bus_a.dout_last, bus_a.dout_keep, bus_a.dout};
    if (rst) begin
      hold_a = 1'b0;
    end else begin
      if (done_a) done_cnt_a++;
      if (hold_a) begin
        check("valid_held_a", 64'(bus_a.dout_valid), 64'(1));
        if (bus_a.dout_valid) check("stable_a", 64'(cur), 64'(held_a));
      end
      hold_a = 1'b0;
      if (bus_a.dout_valid && bus_a.dout_ready) begin
        check("exp_avail_a", 64'(exp_a.size() > 0), 64'(1));
        if (exp_a.size() > 0) begin
          e = exp_a.pop_front();
          check("word_a", 64'(cur), 64'(e));
        end
        if (bus_a.dout_sect == 2'd2 && cnt_a_u < 2) first_u_a[cnt_a_u] = bus_a.dout;
        if (bus_a.dout_sect == 2'd2 && bus_a.dout_last) ulast_a = {bus_a.dout_keep, bus_a.dout};
        if (bus_a.dout_sect == 2'd2) cnt_a_u++;
        if (bus_a.dout_sect == 2'd3) cnt_a_v++;
        if (bus_a.dout_sect == 2'd1) cnt_a_d++;
        words_a++;
      end else if (bus_a.dout_valid) begin
        hold_a = 1'b1;
        held_a = cur;
      end
    end
  end

  always @(negedge clk) begin
    logic [38:0] cur, e;
    cur = {bus_b.dout_sect, bus_b.dout_last, bus_b.dout_keep, bus_b.dout};
    if (!rst) begin
      if (done_b) done_cnt_b++;
      if (bus_b.dout_valid && bus_b.dout_ready) begin
        check("exp_avail_b", 64'(exp_b.size() > 0), 64'(1));
        if (exp_b.size() > 0) begin
          e = exp_b.pop_front();
          check("word_b", 64'(cur), 64'(e));
        end
        if (bus_b.dout_sect == 2'd2 && bus_b.dout_last) ulast_b = {bus_b.dout_keep, bus_b.dout};
        if (bus_b.dout_sect == 2'd2) cnt_b_u++;
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    bus_a.dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_a.dout_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit need_b);
    int c;
    c = 0;
    while (!(done_cnt_a >= 1 && (!need_b || done_cnt_b >= 1)) && c < budget) begin
      @(posedge clk);
      c++;
    end
    check(name, 64'(c < budget), 64'(1));
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_type"},  64'(bus_a.encap_out_type), 64'(0));
    check({tag, "_en"},    64'(bus_a.encap_out_en), 64'(0));
    check({tag, "_addr"},  64'(bus_a.encap_out_addr), 64'(0));
    check({tag, "_dout"},  64'({bus_a.dout, bus_a.dout_keep, bus_a.dout_sect, bus_a.dout_last}), 64'(0));
    check({tag, "_valid"}, 64'(bus_a.dout_valid), 64'(0));
    check({tag, "_busy"},  64'(busy_a), 64'(0));
    check({tag, "_done"},  64'(done_a), 64'(0));
    check({tag, "_state"}, 64'(dbg_a), 64'(ST_IDLE));
  endtask

  task automatic check_totals_a(input string tag);
    check({tag, "_q_empty"}, 64'(exp_a.size()), 64'(0));
    check({tag, "_u_words"}, 64'(cnt_a_u), 64'(553));
    check({tag, "_v_words"}, 64'(cnt_a_v), 64'(553));
    check({tag, "_d_words"}, 64'(cnt_a_d), 64'(16));
    check({tag, "_done_cnt"}, 64'(done_cnt_a), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    bus_b.dout_ready = 1'b1;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_a("reset_a");
    check("reset_b_outs", 64'({bus_b.encap_out_en, bus_b.dout_valid, busy_b, done_b, bus_b.dout}), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat ($urandom_range(1, 4)) @(posedge clk);

    // Run 1: full throughput on both instances, latency and byte order.
    build_model(BYTES_A);
    foreach (model_q[i]) exp_a.push_back(model_q[i]);
    build_model(BYTES_B);
    foreach (model_q[i]) exp_b.push_back(model_q[i]);
    @(posedge clk); #1 start_a = 1'b1; start_b = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    check("rd_cycle_en", 64'({bus_a.encap_out_en, bus_a.encap_out_type, busy_a}), 64'({1'b1, 2'd2, 1'b1}));
    @(negedge clk);
    check("wait_cycle_valid", 64'(bus_a.dout_valid), 64'(0));
    @(negedge clk);
    check("latency_valid", 64'(bus_a.dout_valid), 64'(1));
    wait_done("run1_timeout", 20000, 1'b1);
    repeat (5) @(posedge clk);
    check_totals_a("run1");
    check("byte_order_w0", 64'(first_u_a[0]), 64'(32'h03020100));
    check("byte_order_w1", 64'(first_u_a[1]), 64'(32'h07060504));
    check("u_tail_keep_a", 64'(ulast_a[35:32]), 64'(4'b0001));
    check("u_tail_pad_a", 64'(ulast_a[31:8]), 64'(0));
    check("busy_after_a", 64'(busy_a), 64'(0));
    check("b_q_empty", 64'(exp_b.size()), 64'(0));
    check("b_u_words", 64'(cnt_b_u), 64'(1802));
    check("b_u_tail_keep", 64'(ulast_b[35:32]), 64'(4'b0001));
    check("b_done_cnt", 64'(done_cnt_b), 64'(1));

    // Run 2: 30% ready, plus a start pulse while busy at word 100.
    clear_counts();
    build_model(BYTES_A);
    foreach (model_q[i]) exp_a.push_back(model_q[i]);
    rand_ready = 1'b1;
    pulse_start_a();
    c = 0;
    while (words_a < 100 && c < 5000) begin @(posedge clk); c++; end
    check("reach_word100", 64'(c < 5000), 64'(1));
    pulse_start_a();
    wait_done("run2_timeout", 30000, 1'b0);
    rand_ready = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_totals_a("run2");
    check("run2_idle_valid", 64'(bus_a.dout_valid), 64'(0));
    check("run2_idle_busy", 64'(busy_a), 64'(0));

    // Run 3: reset during v, then a clean restart from u addr 0.
    clear_counts();
    build_model(BYTES_A);
    foreach (model_q[i]) exp_a.push_back(model_q[i]);
    pulse_start_a();
    c = 0;
    while (cnt_a_v < 10 && c < 5000) begin @(posedge clk); c++; end
    check("reach_v", 64'(c < 5000), 64'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_a("midrst");
    exp_a.delete();
    clear_counts();
    build_model(BYTES_A);
    foreach (model_q[i]) exp_a.push_back(model_q[i]);
    pulse_start_a();
    wait_done("run3_timeout", 20000, 1'b0);
    repeat (5) @(posedge clk);
    check_totals_a("run3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
